plic_claim_master: RTL and testbench

Hardware interrupt-handling agent for one PLIC target context. It watches that target's interrupt notification line and acts as the register-bus initiator toward the PLIC: it programs the target's threshold once after reset, reads the claim/complete register to obtain the winning source ID, and hands the ID to a local consumer over a valid/ready handshake. Once the consumer signals that handling is finished, it writes the ID back to the claim/complete register. It replaces a software hart for accelerator-side interrupt contexts.

---
 rtl/plic_claim_master_pkg.sv | 19 +
 rtl/plic_claim_master.sv | 142 ++++++++++++++
 tb/tb_plic_claim_master.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/plic_claim_master_pkg.sv
// Register-bus request/response bundles shared by the
// PLIC claim master and its bus peers.
package plic_claim_master_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/plic_claim_master.sv
// Hardware claim/complete agent for one PLIC target context:
// programs the threshold, claims, dispatches and completes IDs.
module plic_claim_master
  import plic_claim_master_pkg::*;
#(
  parameter int          N_SOURCE  = 30,
  parameter int          SRCW      = $clog2(N_SOURCE + 1),
  parameter int          TARGET    = 0,
  parameter logic [31:0] BASE_ADDR = 32'h0C00_0000,
  parameter int          THRESHOLD = 0,
  parameter int          HOLDOFF   = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            eip_i,
  output reg_req_t        req_o,
  input  reg_rsp_t        rsp_i,
  output logic [SRCW-1:0] irq_id_o,
  output logic            irq_valid_o,
  input  logic            irq_ready_i,
  input  logic            done_i,
  output logic            busy_o,
  output logic [7:0]      err_cnt_o
);

  localparam logic [31:0] TH_ADDR =
    BASE_ADDR + 32'h0020_0000 + 32'(TARGET) * 32'h1000;
  localparam logic [31:0] CC_ADDR = TH_ADDR + 32'd4;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    INIT_WR,
    IDLE,
    CLAIM_RD,
    DISPATCH,
    WAIT_DONE,
    COMPLETE_WR,
    HOLD
  } state_e;

  state_e        state;
  logic [HW-1:0] hold_cnt;
  logic          xfer;
  logic          unused_rdata;

  assign xfer = req_o.valid && rsp_i.ready;
  assign unused_rdata = ^rsp_i.rdata[31:SRCW];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= INIT_WR;
      req_o       <= '0;
      irq_id_o    <= '0;
      irq_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      err_cnt_o   <= '0;
      hold_cnt    <= '0;
    end else begin
      if (xfer && rsp_i.error && err_cnt_o != 8'hFF)
        err_cnt_o <= err_cnt_o + 8'd1;

      unique case (state)
        INIT_WR: begin
          if (!req_o.valid) begin
            req_o <= '{addr:  TH_ADDR,
                       write: 1'b1,
                       wdata: 32'(THRESHOLD),
                       wstrb: 4'hF,
                       valid: 1'b1};
          end else if (rsp_i.ready) begin
            req_o <= '0;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (eip_i) begin
            state  <= CLAIM_RD;
            busy_o <= 1'b1;
          end
        end
        CLAIM_RD: begin
          if (!req_o.valid) begin
            req_o <= '{addr:  CC_ADDR,
                       write: 1'b0,
                       wdata: 32'd0,
                       wstrb: 4'h0,
                       valid: 1'b1};
          end else if (rsp_i.ready) begin
            req_o <= '0;
            // errors and spurious ID 0 both skip dispatch and complete
            if (rsp_i.error || rsp_i.rdata[SRCW-1:0] == '0) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end else begin
              irq_id_o    <= rsp_i.rdata[SRCW-1:0];
              irq_valid_o <= 1'b1;
              state       <= DISPATCH;
            end
          end
        end
        DISPATCH: begin
          if (irq_ready_i) begin
            irq_valid_o <= 1'b0;
            state       <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done_i) state <= COMPLETE_WR;
        end
        COMPLETE_WR: begin
          if (!req_o.valid) begin
            req_o <= '{addr:  CC_ADDR,
                       write: 1'b1,
                       wdata: 32'(irq_id_o),
                       wstrb: 4'hF,
                       valid: 1'b1};
          end else if (rsp_i.ready) begin
            req_o    <= '0;
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          // masks the stale eip while the PLIC re-evaluates
          if (hold_cnt == HOLD_LAST) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          req_o  <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plic_claim_master.sv
// Directed bench for plic_claim_master: init, claim,
// dispatch, complete, wait states, errors and reset.
module tb_plic_claim_master;
  import plic_claim_master_pkg::*;

  localparam int SRCW = 5;
  localparam logic [31:0] TH = 32'h0C20_1000;
  localparam logic [31:0] CC = 32'h0C20_1004;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            eip = 1'b0;
  logic            irq_ready = 1'b0;
  logic            done = 1'b0;
  reg_req_t        req;
  reg_rsp_t        rsp = '0;
  logic [SRCW-1:0] irq_id;
  logic            irq_valid;
  logic            busy;
  logic [7:0]      err_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  plic_claim_master #(
    .N_SOURCE (30),
    .TARGET   (1),
    .BASE_ADDR(32'h0C00_0000),
    .THRESHOLD(3),
    .HOLDOFF  (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .eip_i      (eip),
    .req_o      (req),
    .rsp_i      (rsp),
    .irq_id_o   (irq_id),
    .irq_valid_o(irq_valid),
    .irq_ready_i(irq_ready),
    .done_i     (done),
    .busy_o     (busy),
    .err_cnt_o  (err_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Serve one bus access: wait for valid, hold ready low w cycles.
  task automatic xfer(input string tag, input int w,
                      input logic [31:0] rd, input logic er,
                      input logic [31:0] a, input logic wr,
                      input logic [31:0] wd);
    reg_req_t exp_req;
    int t = 0;
    exp_req = '{addr: a, write: wr, wdata: wd,
                wstrb: wr ? 4'hF : 4'h0, valid: 1'b1};
    while (!req.valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " valid"}, 32'(req.valid), 32'd1);
    if (!req.valid) return;
    chk({tag, " addr"}, req.addr, a);
    chk({tag, " wdata"}, req.wdata, wd);
    chk({tag, " req"}, 32'(req === exp_req), 32'd1);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk({tag, " hold"}, 32'(req === exp_req), 32'd1);
    end
    rsp = '{rdata: rd, error: er, ready: 1'b1};
    @(negedge clk);
    rsp = '0;
    chk({tag, " drop"}, 32'(req.valid), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst req", 32'(req === '0), 32'd1);
    chk("rst irq_valid", 32'(irq_valid), 32'd0);
    chk("rst irq_id", 32'(irq_id), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err_cnt), 32'd0);

    // threshold write right after release
    rst_n = 1'b1;
    @(negedge clk);
    chk("thr first", 32'(req.valid), 32'd1);
    xfer("thr", 0, 32'd0, 1'b0, TH, 1'b1, 32'd3);
    repeat (2) @(negedge clk);
    chk("idle valid", 32'(req.valid), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);

    // zero-wait claim, 3-cycle eip to irq_valid
    eip = 1'b1;
    @(negedge clk);
    chk("lat1 irq_valid", 32'(irq_valid), 32'd0);
    chk("lat1 req", 32'(req.valid), 32'd0);
    @(negedge clk);
    xfer("claim", 0, 32'd5, 1'b0, CC, 1'b0, 32'd0);
    chk("lat3 irq_valid", 32'(irq_valid), 32'd1);
    chk("claim id", 32'(irq_id), 32'd5);
    chk("claim busy", 32'(busy), 32'd1);
    eip = 1'b0;
    @(negedge clk);
    chk("disp hold valid", 32'(irq_valid), 32'd1);
    chk("disp hold id", 32'(irq_id), 32'd5);
    irq_ready = 1'b1;
    @(negedge clk);
    irq_ready = 1'b0;
    chk("disp drop", 32'(irq_valid), 32'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("done lat1", 32'(req.valid), 32'd0);
    @(negedge clk);
    xfer("cc", 0, 32'd0, 1'b0, CC, 1'b1, 32'd5);
    chk("hold0 busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("hold1 busy", 32'(busy), 32'd1);
    chk("hold1 valid", 32'(req.valid), 32'd0);
    @(negedge clk);
    chk("hold end busy", 32'(busy), 32'd0);

    // four wait states per access, ready held high by consumer
    irq_ready = 1'b1;
    eip = 1'b1;
    xfer("claimw", 4, 32'hFFFF_FFE7, 1'b0, CC, 1'b0, 32'd0);
    chk("claimw valid", 32'(irq_valid), 32'd1);
    chk("claimw id", 32'(irq_id), 32'd7);
    eip = 1'b0;
    @(negedge clk);
    chk("claimw drop", 32'(irq_valid), 32'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    xfer("ccw", 4, 32'd0, 1'b0, CC, 1'b1, 32'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ccw single", 32'(req.valid), 32'd0);
    end
    chk("ccw busy", 32'(busy), 32'd0);

    // spurious claim
    eip = 1'b1;
    xfer("spur", 0, 32'd0, 1'b0, CC, 1'b0, 32'd0);
    eip = 1'b0;
    chk("spur irq_valid", 32'(irq_valid), 32'd0);
    chk("spur busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("spur no bus", 32'(req.valid), 32'd0);
      chk("spur no irq", 32'(irq_valid), 32'd0);
    end
    chk("spur idle", 32'(busy), 32'd0);

    // error responses and saturation
    eip = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xfer("err", 0, 32'd4, 1'b1, CC, 1'b0, 32'd0);
      chk("err no irq", 32'(irq_valid), 32'd0);
    end
    eip = 1'b0;
    chk("err cnt3", 32'(err_cnt), 32'd3);
    repeat (4) @(negedge clk);
    eip = 1'b1;
    for (int i = 0; i < 300; i++)
      xfer("sat", 0, 32'd0, 1'b1, CC, 1'b0, 32'd0);
    eip = 1'b0;
    chk("err sat", 32'(err_cnt), 32'hFF);
    repeat (4) @(negedge clk);

    // reset while waiting for done
    eip = 1'b1;
    xfer("claimr", 0, 32'd9, 1'b0, CC, 1'b0, 32'd0);
    eip = 1'b0;
    chk("claimr id", 32'(irq_id), 32'd9);
    @(negedge clk);
    chk("claimr busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst req", 32'(req === '0), 32'd1);
    chk("arst irq_valid", 32'(irq_valid), 32'd0);
    chk("arst irq_id", 32'(irq_id), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst err", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer("thr2", 0, 32'd0, 1'b0, TH, 1'b1, 32'd3);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stray done bus", 32'(req.valid), 32'd0);
      chk("stray done busy", 32'(busy), 32'd0);
    end

    // reset with a claim read in flight
    eip = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid valid", 32'(req.valid), 32'd1);
    rst_n = 1'b0;
    eip = 1'b0;
    #1;
    chk("mid arst valid", 32'(req.valid), 32'd0);
    chk("mid arst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer("thr3", 0, 32'd0, 1'b0, TH, 1'b1, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
